vga_window_timing: RTL and testbench
====================================

Name: vga_window_timing

Overview:
- Parametrised successor to the fixed 1024x768 VGA synch generator.
- Generates programmable-resolution VGA timing with configurable sync polarity.
- Also places an IMG_H x IMG_V picture window on the active area and produces a linear picture-memory read address.
- Output copies delayed by RD_LAT let the picture memory and image editor read latency line up with the sync signals.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- IMG_H, 607, picture width
- IMG_V, 455, picture height
- ADDR_W, 19, picture address width (must satisfy 2^ADDR_W >= IMG_H*IMG_V)
- RD_LAT, 2, pixel-strobe delay stages on the *_d outputs (0..4)

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  synchronous, active-high reset
- pix_stb  in  1  pixel strobe; counters advance only when high
- mode  in  2  window placement: 00 centred, 01 top-left, 10 window disabled, 11 treated as 00
- x  out  11  horizontal count, 0..H_TOTAL-1
- y  out  10  vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  high while x<H_ACTIVE and y<V_ACTIVE
- img_valid  out  1  current (x,y) is inside the picture window
- img_addr  out  ADDR_W  picture address for the current (x,y)
- frame_start  out  1  high while (x,y)=(0,0)
- line_start  out  1  high while x=0
- hsync_d, vsync_d, active_d, img_valid_d  out  1 each  copies delayed by RD_LAT pix_stb steps

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
- Counters, on a pix_stb cycle:
  - x increments; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps from V_TOTAL-1 to 0 on the same cycle that x wraps.
  - When pix_stb is low, every register, including the delay lines, holds.
- Output alignment:
  - All outputs are registered and always describe the (x,y) currently held.
  - No combinational path exists from inputs to outputs.
  - Latency from a pix_stb cycle to the updated outputs is 1 clk.
- Sync:
  - hsync = H_POL while H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
  - vsync follows the same rule on y, using the V_* parameters and V_POL.
- Window origin (X0,Y0), taken from the latched mode:
  - Centred: X0 = (H_ACTIVE-IMG_H)/2, Y0 = (V_ACTIVE-IMG_V)/2, integer division (208,156 at defaults).
  - Top-left: (0,0).
  - Disabled: img_valid stays 0 for the whole frame.
- img_valid = X0 <= x < X0+IMG_H and Y0 <= y < Y0+IMG_V.
- Mode latch:
  - mode is sampled only on the pix_stb cycle that wraps into (0,0).
  - A mid-frame change takes effect at the next frame_start.
  - Reset latches 00.
- Address (counter only, no multiplier):
  - img_addr is 0 at frame_start.
  - It increments by 1 on each pix_stb cycle where img_valid=1.
  - Therefore img_addr = (y-Y0)*IMG_H + (x-X0) throughout the window.
  - Outside the window it holds its last value.
  - The last window pixel gives IMG_H*IMG_V-1.
  - The counter never wraps inside a frame.
- Delay lines: RD_LAT-stage shift registers advanced on pix_stb. RD_LAT=0 makes each *_d identical to its source.
- Reset (synchronous, also when asserted mid-frame), takes effect on the next clk edge:
  - x=0, y=0, img_addr=0.
  - hsync=~H_POL, vsync=~V_POL.
  - frame_start=1, line_start=1.
  - active=1 and img_valid=1 only if the origin is (0,0); otherwise 0.
  - All delay-line stages are cleared to their inactive levels.
- Simultaneous reset and pix_stb: reset wins.

Test Plan:
- Reset with default parameters -> x=0, y=0, hsync=1, vsync=1, active=1, img_valid=0, img_addr=0, frame_start=1, all *_d at inactive levels.
- Run one line with pix_stb=1 every clk -> hsync low exactly for x=1048..1183 (136 pixels); active falls at x=1024; x wraps 1343->0 and y steps 0->1.
- Run a full frame -> vsync low for y=771..776; frame period 1344*806 = 1,083,264 pix_stb cycles; frame_start high once per frame.
- Centred mode -> img_addr = 0 at (208,156), 606 at (814,156), 607 at (208,157), 276184 at (814,610); img_valid count per frame = 276185.
- mode changed 00->01 mid-frame -> current frame stays centred; next frame img_addr=0 at (0,0). mode=10 -> img_valid=0 for the entire frame.
- pix_stb toggling every other clk plus RD_LAT=2 -> img_valid_d equals img_valid two strobes earlier. Reset asserted at y=300 -> next clk x=0, y=0, img_addr=0, and the delay lines are cleared.

Source files
------------

// File: rtl/vga_window_timing.sv
// Programmable VGA timing generator with a placeable picture window and a linear
// picture-memory address counter, plus delayed copies of the main strobes.
module vga_window_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int IMG_H    = 607,
    parameter int IMG_V    = 455,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_stb,
    input  logic [1:0]        mode,
    output logic [10:0]       x,
    output logic [9:0]        y,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              img_valid,
    output logic [ADDR_W-1:0] img_addr,
    output logic              frame_start,
    output logic              line_start,
    output logic              hsync_d,
    output logic              vsync_d,
    output logic              active_d,
    output logic              img_valid_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CX0     = (H_ACTIVE - IMG_H) / 2;
    localparam int CY0     = (V_ACTIVE - IMG_V) / 2;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] CX_BEG  = 11'(CX0);
    localparam logic [10:0] CX_END  = 11'(CX0 + IMG_H);
    localparam logic [10:0] TX_END  = 11'(IMG_H);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  CY_BEG  = 10'(CY0);
    localparam logic [9:0]  CY_END  = 10'(CY0 + IMG_V);
    localparam logic [9:0]  TY_END  = 10'(IMG_V);

    localparam logic              HS_ON     = 1'(H_POL);
    localparam logic              VS_ON     = 1'(V_POL);
    localparam logic              RST_VALID = (CX0 == 0) && (CY0 == 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_H * IMG_V - 1);
    localparam logic [3:0]        TAP_IDLE  = {1'b0, 1'b0, ~VS_ON, ~HS_ON};

    // mode_reg only ever holds 00, 01 or 10; 11 is folded to 00 when latched.
    function automatic logic in_window(input logic [10:0] px, input logic [9:0] py,
                                       input logic [1:0] m);
        logic [10:0] xb, xe;
        logic [9:0]  yb, ye;
        if (m == 2'b01) begin
            xb = '0;     xe = TX_END; yb = '0;     ye = TY_END;
        end else begin
            xb = CX_BEG; xe = CX_END; yb = CY_BEG; ye = CY_END;
        end
        return (m != 2'b10) && (px >= xb) && (px < xe) && (py >= yb) && (py < ye);
    endfunction

    logic [10:0]       x_reg, x_next;
    logic [9:0]        y_reg, y_next;
    logic [1:0]        mode_reg, mode_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              hsync_reg, vsync_reg, active_reg, img_valid_reg;
    logic              frame_start_reg, line_start_reg;
    logic              frame_wrap;

    // Position after one pixel step; only committed on a pix_stb cycle.
    always_comb begin
        x_next     = x_reg + 11'd1;
        y_next     = y_reg;
        mode_next  = mode_reg;
        addr_next  = addr_reg;
        frame_wrap = 1'b0;
        if (x_reg == H_LAST) begin
            x_next = '0;
            if (y_reg == V_LAST) begin
                y_next     = '0;
                frame_wrap = 1'b1;
            end else begin
                y_next = y_reg + 10'd1;
            end
        end
        if (frame_wrap) begin
            mode_next = (mode == 2'b11) ? 2'b00 : mode;
            addr_next = '0;
        end else if (img_valid_reg && (addr_reg != ADDR_LAST)) begin
            addr_next = addr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg           <= '0;
            y_reg           <= '0;
            mode_reg        <= 2'b00;
            addr_reg        <= '0;
            hsync_reg       <= ~HS_ON;
            vsync_reg       <= ~VS_ON;
            active_reg      <= 1'b1;
            img_valid_reg   <= RST_VALID;
            frame_start_reg <= 1'b1;
            line_start_reg  <= 1'b1;
        end else if (pix_stb) begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            mode_reg        <= mode_next;
            addr_reg        <= addr_next;
            hsync_reg       <= ((x_next >= HS_BEG) && (x_next < HS_END)) ? HS_ON : ~HS_ON;
            vsync_reg       <= ((y_next >= VS_BEG) && (y_next < VS_END)) ? VS_ON : ~VS_ON;
            active_reg      <= (x_next < H_ACT) && (y_next < V_ACT);
            img_valid_reg   <= in_window(x_next, y_next, mode_next);
            frame_start_reg <= frame_wrap;
            line_start_reg  <= (x_next == 11'd0);
        end
    end

    assign x           = x_reg;
    assign y           = y_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign active      = active_reg;
    assign img_valid   = img_valid_reg;
    assign img_addr    = addr_reg;
    assign frame_start = frame_start_reg;
    assign line_start  = line_start_reg;

    // Delay line taps: {img_valid, active, vsync, hsync}, advanced per pixel.
    logic [3:0] tap_src, tap_out;
    assign tap_src = {img_valid_reg, active_reg, vsync_reg, hsync_reg};

    genvar gi;
    generate
        if (RD_LAT == 0) begin : g_no_delay
            assign tap_out = tap_src;
        end else begin : g_delay
            for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
                logic [3:0] stage_reg;
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (reset)        stage_reg <= TAP_IDLE;
                        else if (pix_stb) stage_reg <= tap_src;
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (reset)        stage_reg <= TAP_IDLE;
                        else if (pix_stb) stage_reg <= g_stage[gi-1].stage_reg;
                    end
                end
            end
            assign tap_out = g_stage[RD_LAT-1].stage_reg;
        end
    endgenerate

    assign hsync_d     = tap_out[0];
    assign vsync_d     = tap_out[1];
    assign active_d    = tap_out[2];
    assign img_valid_d = tap_out[3];

endmodule

// File: tb/tb_vga_window_timing.sv
// Randomised bench for vga_window_timing on a shrunken raster, checked against a
// position-counting reference model.
module tb_vga_window_timing;

    localparam int HA = 20, HF = 2, HS = 3, HB = 4;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int IH = 7, IV = 5, AW = 6, LAT = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit HP = 1'b0, VP = 1'b1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_stb = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [10:0]   x;
    logic [9:0]    y;
    logic          hsync, vsync, active, img_valid, frame_start, line_start;
    logic [AW-1:0] img_addr;
    logic          hsync_d, vsync_d, active_d, img_valid_d;

    vga_window_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(0), .V_POL(1), .IMG_H(IH), .IMG_V(IV), .ADDR_W(AW), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .pix_stb(pix_stb), .mode(mode),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .active(active),
        .img_valid(img_valid), .img_addr(img_addr), .frame_start(frame_start),
        .line_start(line_start), .hsync_d(hsync_d), .vsync_d(vsync_d),
        .active_d(active_d), .img_valid_d(img_valid_d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: raster position, frame mode, and history for the delayed taps.
    int         mx = 0, my = 0, fm = 0;
    int         valid_cnt = 0;
    logic [3:0] dq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (x=%0d y=%0d)", tag, obs, exp, mx, my);
        end
    endtask

    function automatic int org_x(input int f);
        return (f == 1) ? 0 : (HA - IH) / 2;
    endfunction

    function automatic int org_y(input int f);
        return (f == 1) ? 0 : (VA - IV) / 2;
    endfunction

    function automatic bit m_win(input int xx, input int yy, input int f);
        if (f == 2) return 1'b0;
        return xx >= org_x(f) && xx < org_x(f) + IH && yy >= org_y(f) && yy < org_y(f) + IV;
    endfunction

    function automatic logic [3:0] m_tuple();
        bit hs_b, vs_b, act_b;
        hs_b  = (mx >= HA + HF && mx < HA + HF + HS) ? HP : !HP;
        vs_b  = (my >= VA + VF && my < VA + VF + VS) ? VP : !VP;
        act_b = (mx < HA) && (my < VA);
        return {m_win(mx, my, fm), act_b, vs_b, hs_b};
    endfunction

    task automatic check_all();
        logic [3:0] t, td;
        int ox, oy;
        t  = m_tuple();
        td = (LAT == 0) ? t : dq[0];
        ox = org_x(fm);
        oy = org_y(fm);
        chk("x", 32'(x), 32'(mx));
        chk("y", 32'(y), 32'(my));
        chk("hsync", 32'(hsync), 32'(t[0]));
        chk("vsync", 32'(vsync), 32'(t[1]));
        chk("active", 32'(active), 32'(t[2]));
        chk("img_valid", 32'(img_valid), 32'(t[3]));
        chk("frame_start", 32'(frame_start), 32'(mx == 0 && my == 0));
        chk("line_start", 32'(line_start), 32'(mx == 0));
        if (t[3])
            chk("img_addr_win", 32'(img_addr), 32'((my - oy) * IH + (mx - ox)));
        else if (fm == 2 || my < oy || (my == oy && mx < ox))
            chk("img_addr_pre", 32'(img_addr), 32'd0);
        chk("hsync_d", 32'(hsync_d), 32'(td[0]));
        chk("vsync_d", 32'(vsync_d), 32'(td[1]));
        chk("active_d", 32'(active_d), 32'(td[2]));
        chk("img_valid_d", 32'(img_valid_d), 32'(td[3]));
    endtask

    // One clock: drive inputs, advance the model as the spec dictates, compare everything.
    task automatic tick(input logic r, input logic s, input logic [1:0] m);
        logic pre_valid;
        int   old_fm;
        pre_valid = img_valid;
        reset   = r;
        pix_stb = s;
        mode    = m;
        @(posedge clk);
        #1;
        if (r) begin
            mx = 0; my = 0; fm = 0; valid_cnt = 0;
            dq.delete();
            for (int i = 0; i < LAT; i++) dq.push_back({1'b0, 1'b0, !VP, !HP});
        end else if (s) begin
            dq.push_back(m_tuple());
            while (dq.size() > LAT) void'(dq.pop_front());
            valid_cnt += int'(pre_valid);
            mx++;
            if (mx == HT) begin
                mx = 0;
                my++;
                if (my == VT) my = 0;
            end
            if (mx == 0 && my == 0) begin
                old_fm = fm;
                fm = (m == 2'b11) ? 0 : int'(m);
                chk("frame_valid_cnt", 32'(valid_cnt), 32'((old_fm == 2) ? 0 : IH * IV));
                $display("frame done: mode=%0d valid pixels=%0d next mode=%0d", old_fm, valid_cnt, fm);
                valid_cnt = 0;
            end
        end
        check_all();
    endtask

    task automatic run_until(input int tx, input int ty, input int pct, input logic [1:0] m,
                             input int bound);
        int n;
        n = 0;
        do begin
            tick(1'b0, 1'($urandom_range(0, 99) < pct), m);
            n++;
        end while (!(mx == tx && my == ty) && n < bound);
        chk("reach_x", 32'(x), 32'(tx));
        chk("reach_y", 32'(y), 32'(ty));
        $display("reached (%0d,%0d) after %0d clk with mode=%0d", x, y, n, m);
    endtask

    initial begin
        // Reset, with random pix_stb to show reset wins.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'($urandom_range(0, 1)), 2'b00);
        $display("reset: x=%0d y=%0d hsync=%0d vsync=%0d addr=%0d", x, y, hsync, vsync, img_addr);

        // One full line at one strobe per clock.
        for (int i = 0; i < HT; i++) tick(1'b0, 1'b1, 2'b00);
        $display("line done: x=%0d y=%0d", x, y);

        // Finish the centred frame with random strobes.
        run_until(0, 0, 75, 2'b00, 4000);
        // Change to top-left mid-frame; the current frame must stay centred.
        run_until(0, VT / 2, 75, 2'b00, 4000);
        run_until(0, 0, 75, 2'b01, 4000);
        run_until(0, 0, 75, 2'b10, 4000);
        run_until(0, 0, 75, 2'b11, 4000);
        run_until(0, 0, 90, 2'b00, 4000);

        // Strobe every other clock.
        for (int i = 0; i < 200; i++) tick(1'b0, 1'(i % 2), 2'b00);
        $display("toggle phase done: x=%0d y=%0d", x, y);

        // Mid-frame reset coinciding with a strobe.
        run_until(5, 8, 80, 2'b00, 4000);
        tick(1'b1, 1'b1, 2'b01);
        $display("mid-frame reset: x=%0d y=%0d addr=%0d vd=%0d", x, y, img_addr, img_valid_d);
        run_until(0, 0, 70, 2'b01, 4000);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
